// File: rtl/sliding_window_adder.sv
// Running sum of the most recent W accepted samples, W latched at rst/clr.
// History lives in a circular buffer; the evicted sample is subtracted once the window is full.
module sliding_window_adder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [N:0]      win_len,
  input  logic            in_valid,
  input  logic [DW-1:0]   inp,
  output logic            out_valid,
  output logic [DW+N-1:0] outp,
  output logic            primed
);
  localparam int         SW    = DW + N;
  localparam int         DEPTH = 1 << N;
  localparam logic [N:0] MAXW  = (N+1)'(DEPTH);
  localparam logic [N:0] ONE   = (N+1)'(1);

  function automatic logic [N:0] clamp_len(input logic [N:0] l);
    if (l == '0)  return ONE;
    if (l > MAXW) return MAXW;
    return l;
  endfunction

  logic [DW-1:0] mem [DEPTH];
  logic [N-1:0]  wptr, rptr;
  logic [N:0]    wlen, count, cnt_next;
  logic [SW-1:0] sum_q, sum_next;
  logic [DW-1:0] oldest;
  logic          full, acc;

  assign acc  = in_valid & ~clr & ~rst;
  assign full = (count == wlen);
  // W = 2**N aliases rptr onto wptr; the array read sees the pre-write value.
  assign rptr = wptr - wlen[N-1:0];
  assign oldest   = full ? mem[rptr] : '0;
  assign sum_next = sum_q + {{N{1'b0}}, inp} - {{N{1'b0}}, oldest};
  assign cnt_next = full ? count : count + ONE;

  // Buffer is intentionally unreset; count gating keeps stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (acc) mem[wptr] <= inp;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wlen      <= clamp_len(win_len);
      sum_q     <= '0;
      count     <= '0;
      wptr      <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (in_valid) begin
      wptr      <= wptr + 1'b1;
      count     <= cnt_next;
      sum_q     <= sum_next;
      out_valid <= 1'b1;
      primed    <= (cnt_next == wlen);
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign outp = sum_q;
endmodule

// File: tb/tb_sliding_window_adder.sv
// Directed + random stimulus against a queue-based window-sum model.
module tb_sliding_window_adder;
  logic        clk = 1'b0;
  logic        rst, clr, in_valid;
  logic [4:0]  win_len;
  logic [7:0]  inp;
  logic        out_valid, primed;
  logic [11:0] outp;

  int total = 0;
  int bad   = 0;

  int         mw;
  int         q[$];
  logic [11:0] e_sum;
  logic        e_ov, e_pr;

  sliding_window_adder #(.N(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .win_len(win_len), .in_valid(in_valid),
    .inp(inp), .out_valid(out_valid), .outp(outp), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic cyc(input logic r, input logic c, input logic v, input logic [7:0] d,
                     input logic [4:0] wl);
    int s;
    rst = r; clr = c; in_valid = v; inp = d; win_len = wl;
    @(posedge clk); #1;
    if (r || c) begin
      q.delete();
      mw = (wl == 0) ? 1 : (wl > 16) ? 16 : int'(wl);
      e_sum = 0; e_ov = 0; e_pr = 0;
    end else if (v) begin
      q.push_back(int'(d));
      if (q.size() > mw) void'(q.pop_front());
      s = 0;
      foreach (q[i]) s += q[i];
      e_sum = 12'(s); e_ov = 1; e_pr = (q.size() == mw);
    end else begin
      e_ov = 0;
    end
    chk("outp", 32'(outp), 32'(e_sum));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("primed", 32'(primed), 32'(e_pr));
  endtask

  initial begin
    rst = 1; clr = 0; in_valid = 0; inp = 0; win_len = 4;
    #1;
    // 1: reset with random traffic
    repeat (2) cyc(1, 0, 1'($urandom), 8'($urandom), 5'd4);
    cyc(0, 0, 0, 8'($urandom), 5'd4);
    // 2: W=4 ramp
    for (int i = 1; i <= 6; i++) cyc(0, 0, 1, 8'(i), 5'($urandom));
    chk("ramp_final", 32'(outp), 32'd18);
    // 3: W=16 full-scale, wraps the pointer
    cyc(1, 0, 0, 0, 5'd16);
    for (int i = 1; i <= 20; i++) cyc(0, 0, 1, 8'd255, 5'd3);
    chk("fullscale_final", 32'(outp), 32'd4080);
    // 4: W=2 with a gap
    cyc(0, 1, 0, 0, 5'd2);
    cyc(0, 0, 1, 8'd10, 5'd2);
    repeat (3) cyc(0, 0, 0, 8'($urandom), 5'd2);
    cyc(0, 0, 1, 8'd20, 5'd2);
    cyc(0, 0, 1, 8'd30, 5'd2);
    chk("gap_final", 32'(outp), 32'd50);
    // 5: clr mid-stream drops the sample and relatches W=3
    cyc(0, 1, 0, 0, 5'd4);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'($urandom), 5'd4);
    cyc(0, 1, 1, 8'd99, 5'd3);
    repeat (4) cyc(0, 0, 1, 8'd7, 5'd9);
    chk("clr_final", 32'(outp), 32'd21);
    // 6: win_len clamps
    cyc(0, 1, 0, 0, 5'd0);
    repeat (6) cyc(0, 0, 1, 8'($urandom), 5'd5);
    cyc(0, 1, 0, 0, 5'd31);
    repeat (18) cyc(0, 0, 1, 8'($urandom), 5'd2);
    // random soak
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
          1'($urandom), 8'($urandom), 5'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
